// File: rtl/walk_arbiter_if.sv
// Shared bus between the page-walk requesters, the arbiter and the single memory read port.
// master is the arbiter's view; slave is the requester/memory side.
interface walk_arbiter_if #(
  parameter int REQ_NUM = 3
);
  logic [REQ_NUM-1:0]    req_ren;
  logic [32*REQ_NUM-1:0] req_addr;
  logic [REQ_NUM-1:0]    req_ack;
  logic [REQ_NUM-1:0]    req_err;
  logic [31:0]           req_data;
  logic                  mem_ren;
  logic [31:0]           mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_data;

  modport master (
    input  req_ren, req_addr, mem_ack, mem_data,
    output req_ack, req_err, req_data, mem_ren, mem_addr
  );

  modport slave (
    output req_ren, req_addr, mem_ack, mem_data,
    input  req_ack, req_err, req_data, mem_ren, mem_addr
  );
endinterface

// File: rtl/walk_arbiter.sv
// Round-robin arbiter sharing one memory read port among page-walk requesters,
// with chained-read port holding, abort on ren drop and a per-read timeout.
module walk_arbiter #(
  parameter int REQ_NUM = 3,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  walk_arbiter_if.master  bus
);
  localparam int IW = $clog2(REQ_NUM);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

  state_e               state_q;
  logic [IW-1:0]        g_q;
  logic [IW-1:0]        ptr_q;
  logic [31:0]          lat_addr_q;
  logic [7:0]           tcnt_q;
  logic [REQ_NUM-1:0]   err_q;

  logic                 sel_ren_d;
  logic [31:0]          sel_addr_d;
  logic [IW-1:0]        pick_d;
  logic [31:0]          pick_addr_d;
  logic [IW-1:0]        ptr_d;
  logic [REQ_NUM-1:0]   ack_d;

  // Lowest offset from p wins; scanning offsets downward lets the last hit stand.
  function automatic logic [IW-1:0] pick_next(input logic [REQ_NUM-1:0] ren,
                                              input logic [IW-1:0] p);
    logic [IW-1:0] sel;
    int idx;
    sel = p;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % REQ_NUM;
      if (ren[idx]) sel = IW'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    sel_ren_d   = bus.req_ren[g_q];
    sel_addr_d  = bus.req_addr[32*g_q +: 32];
    pick_d      = pick_next(bus.req_ren, ptr_q);
    pick_addr_d = bus.req_addr[32*pick_d +: 32];
    ptr_d       = (g_q == IW'(REQ_NUM - 1)) ? '0 : g_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      ptr_q      <= '0;
      lat_addr_q <= '0;
      tcnt_q     <= '0;
      err_q      <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        IDLE: begin
          if (|bus.req_ren) begin
            g_q        <= pick_d;
            lat_addr_q <= pick_addr_d;
            tcnt_q     <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // Ack beats both abort and timeout.
          if (bus.mem_ack) begin
            ptr_q   <= ptr_d;
            state_q <= GAP;
          end else if (!sel_ren_d) begin
            state_q <= IDLE;
          end else if (tcnt_q == 8'(TIMEOUT)) begin
            err_q[g_q] <= 1'b1;
            ptr_q      <= ptr_d;
            state_q    <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        GAP: begin
          // A changed address under a held ren is the next level of the same walk.
          if (sel_ren_d && (sel_addr_d != lat_addr_q)) begin
            lat_addr_q <= sel_addr_d;
            tcnt_q     <= '0;
            state_q    <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ack_d = '0;
    if (state_q == BUSY) ack_d[g_q] = bus.mem_ack;
  end

  assign bus.req_ack  = ack_d;
  assign bus.req_err  = err_q;
  assign bus.req_data = bus.mem_data;
  assign bus.mem_ren  = (state_q == BUSY);
  assign bus.mem_addr = lat_addr_q;
endmodule

// File: doc/walk_arbiter.md
WALK_ARBITER -- requirements
Module: walk_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 3, the number of read requesters (2..8): IMMU, DMMU and debug.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack (1..255).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_ren  input  REQ_NUM  per-requester read enable, level held until ack.
REQ-006 req_addr  input  32*REQ_NUM  per-requester read address; requester i uses bits [32i+31:32i].
REQ-007 req_ack  output  REQ_NUM  per-requester acknowledge, one-hot or zero.
REQ-008 req_err  output  REQ_NUM  per-requester timeout error pulse.
REQ-009 req_data  output  32  read data, broadcast to all requesters.
REQ-010 mem_ren  output  1  shared memory read enable.
REQ-011 mem_addr  output  32  shared memory read address.
REQ-012 mem_ack  input  1  memory acknowledge; data is valid in the same cycle.
REQ-013 mem_data  input  32  memory read data.

Function
REQ-014 SHALL implement states IDLE, BUSY and GAP, plus a registered grant index g, a rotating pointer ptr, a latched address lat_addr and an 8-bit timeout counter tcnt.
REQ-015 IDLE: when any req_ren bit is set, SHALL select the first set bit searching upward from ptr with wrap-around, then load g, lat_addr <= req_addr[g], tcnt <= 0, and go to BUSY.
REQ-016 IDLE with no request: SHALL stay in IDLE with mem_ren=0.
REQ-017 mem_ren SHALL be 1 exactly while the state is BUSY, and mem_addr SHALL equal lat_addr at all times.
REQ-018 req_ack[g] SHALL equal mem_ack while BUSY, combinationally, in the same cycle; all other req_ack bits SHALL be 0.
REQ-019 req_data SHALL equal mem_data combinationally; requesters sample it only with req_ack.
REQ-020 BUSY with mem_ack: SHALL go to GAP and set ptr <= (g+1) mod REQ_NUM.
REQ-021 GAP: mem_ren SHALL be 0 for exactly one cycle, so the memory sees a new transaction on any re-issue.
REQ-022 GAP, chained read (req_ren[g]=1 and req_addr[g] != lat_addr): SHALL keep grant g, load lat_addr <= req_addr[g] and tcnt <= 0, and go to BUSY; a two-level page walk therefore holds the port across both reads.
REQ-023 GAP, release (req_ren[g]=0 or req_addr[g] == lat_addr): SHALL go to IDLE; a stale ren held after the final ack is not re-issued.
REQ-024 A requester re-reading an identical address SHALL deassert req_ren for at least one cycle between the two reads.
REQ-025 BUSY, abort (req_ren[g] drops without mem_ack in the same cycle): SHALL go to IDLE next cycle, leave ptr unchanged and drop mem_ren; the memory side tolerates an abandoned read.
REQ-026 BUSY, no mem_ack: tcnt SHALL increment by 1 each cycle.
REQ-027 Timeout: when tcnt == TIMEOUT and mem_ack=0, SHALL pulse req_err[g] for one cycle, set ptr <= (g+1) mod REQ_NUM and go to IDLE.
REQ-028 Simultaneous mem_ack and timeout: mem_ack SHALL win, and req_err SHALL stay 0.
REQ-029 Simultaneous mem_ack and req_ren[g] drop in the same cycle: SHALL be treated as a normal ack per REQ-020.
REQ-030 A request arriving on another port during BUSY or GAP SHALL wait and is never dropped; no requester waits more than REQ_NUM-1 grants of other ports, excluding chained reads.

Reset
REQ-031 On rst, next edge: state=IDLE, g=0, ptr=0, lat_addr=0, tcnt=0.
REQ-032 The cycle after rst: mem_ren=0, mem_addr=0, req_ack=0, req_err=0.
REQ-033 rst asserted mid-BUSY SHALL abandon the read with no ack or err emitted afterwards; rst has priority over every other event.

Verification
REQ-034 Single read: req_ren=001, addr0=0x1000 (memory acks 2 cycles later) -> mem_ren high for 2 cycles with mem_addr=0x1000, req_ack=001 for one cycle, then GAP and IDLE.
REQ-035 Page walk chain: requester1 reads 0x2004; after the ack it holds ren and changes addr to 0x3008 -> second BUSY follows the single GAP cycle with no other grant in between; after the second ack with addr unchanged -> IDLE.
REQ-036 Round robin: req_ren=111 held, each read acked immediately -> grant order 0,1,2,0, with ptr wrapping from 2 to 0.
REQ-037 Timeout: TIMEOUT=4, mem_ack never asserted -> mem_ren high for 5 cycles, req_err pulses on the requester's bit, then IDLE.
REQ-038 Abort and reset: req_ren drops mid-BUSY -> mem_ren=0 next cycle and no ack; rst during BUSY -> all outputs 0 next cycle.
REQ-039 Ack at the timeout boundary: mem_ack arrives in the cycle tcnt==TIMEOUT -> req_ack pulses and req_err stays 0.
